// File: rtl/regfile_alu_if.sv
// Operation/result bundle for the register-file ALU core.
// The master drives the operation fields and the slave (the core) returns
// the Rdest read-back and the status flags.
interface regfile_alu_if;
  logic        En;
  logic [3:0]  RdestRegLoc;
  logic [3:0]  RsrcRegLoc;
  logic [15:0] Imm;
  logic        Imm_s;
  logic [4:0]  OpCode;
  logic [15:0] RdestOut;
  logic [4:0]  Flags;

  modport master (
    output En, RdestRegLoc, RsrcRegLoc, Imm, Imm_s, OpCode,
    input  RdestOut, Flags
  );

  modport slave (
    input  En, RdestRegLoc, RsrcRegLoc, Imm, Imm_s, OpCode,
    output RdestOut, Flags
  );
endinterface

// File: rtl/regfile_alu.sv
// 16 x 16-bit register file fused with a two-operand ALU and a 5-bit
// status register packed as {C, L, F, Z, N}. One operation per enabled
// clock: operand A is R[Rdest], operand B is R[Rsrc] or the immediate,
// and the result is written back to R[Rdest] on the same edge.
module regfile_alu (
  input  logic         Clk,
  input  logic         Rst,
  regfile_alu_if.slave bus
);
  localparam int DATA_W = 16;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_ADDU = 5'b00001;
  localparam logic [4:0] OP_ADDC = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00011;
  localparam logic [4:0] OP_SUBC = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_XOR  = 5'b01000;
  localparam logic [4:0] OP_NOT  = 5'b01001;
  localparam logic [4:0] OP_MOV  = 5'b01010;
  localparam logic [4:0] OP_LSH  = 5'b01011;
  localparam logic [4:0] OP_ASH  = 5'b01100;
  localparam logic [4:0] OP_LUI  = 5'b01101;

  logic [DATA_W-1:0] r_regs [16];
  logic [4:0]        r_flags;

  logic [DATA_W-1:0]        w_a;
  logic [DATA_W-1:0]        w_b;
  logic signed [DATA_W-1:0] w_a_s;
  logic signed [DATA_W-1:0] w_b_s;
  logic                     w_cin;
  logic [DATA_W:0]          w_add;
  logic [DATA_W:0]          w_sub;
  logic                     w_add_ovf;
  logic                     w_sub_ovf;
  logic [DATA_W-1:0]        w_res;
  logic                     w_we;
  logic [4:0]               w_flags_nxt;

  // Shift A by B[3:0]; B[4] selects right, and arith makes a right shift
  // replicate the sign bit instead of filling with zero.
  function automatic logic [DATA_W-1:0] shift_fn(
    input logic [DATA_W-1:0] a,
    input logic [4:0]        ctl,
    input logic              arith
  );
    logic signed [DATA_W-1:0] a_s;
    a_s = $signed(a);
    if (!ctl[4])
      shift_fn = a << ctl[3:0];
    else if (arith)
      shift_fn = $unsigned(a_s >>> ctl[3:0]);
    else
      shift_fn = a >> ctl[3:0];
  endfunction

  // Operand fetch: both operands read the pre-edge register contents.
  assign w_a   = r_regs[bus.RdestRegLoc];
  assign w_b   = bus.Imm_s ? bus.Imm : r_regs[bus.RsrcRegLoc];
  assign w_a_s = $signed(w_a);
  assign w_b_s = $signed(w_b);

  // Only the carry-chained ops consume the stored carry flag.
  assign w_cin = ((bus.OpCode == OP_ADDC) || (bus.OpCode == OP_SUBC)) ? r_flags[4] : 1'b0;

  // 17-bit arithmetic: bit 16 is carry-out for add and borrow for subtract.
  assign w_add     = {1'b0, w_a} + {1'b0, w_b} + {{DATA_W{1'b0}}, w_cin};
  assign w_sub     = {1'b0, w_a} - {1'b0, w_b} - {{DATA_W{1'b0}}, w_cin};
  assign w_add_ovf = (w_a[DATA_W-1] == w_b[DATA_W-1]) && (w_add[DATA_W-1] != w_a[DATA_W-1]);
  assign w_sub_ovf = (w_a[DATA_W-1] != w_b[DATA_W-1]) && (w_sub[DATA_W-1] != w_a[DATA_W-1]);

  // Decode the opcode into a result, a write strobe and the next flag value.
  always_comb begin
    w_res       = '0;
    w_we        = 1'b1;
    w_flags_nxt = r_flags;
    unique case (bus.OpCode)
      OP_ADD, OP_ADDC: begin
        w_res          = w_add[DATA_W-1:0];
        w_flags_nxt[4] = w_add[DATA_W];
        w_flags_nxt[2] = w_add_ovf;
      end
      OP_ADDU: w_res = w_add[DATA_W-1:0];
      OP_SUB, OP_SUBC: begin
        w_res          = w_sub[DATA_W-1:0];
        w_flags_nxt[4] = w_sub[DATA_W];
        w_flags_nxt[2] = w_sub_ovf;
      end
      OP_CMP: begin
        w_we           = 1'b0;
        w_flags_nxt[1] = (w_a == w_b);
        w_flags_nxt[3] = (w_a < w_b);
        w_flags_nxt[0] = (w_a_s < w_b_s);
      end
      OP_AND:  w_res = w_a & w_b;
      OP_OR:   w_res = w_a | w_b;
      OP_XOR:  w_res = w_a ^ w_b;
      OP_NOT:  w_res = ~w_b;
      OP_MOV:  w_res = w_b;
      OP_LSH:  w_res = shift_fn(w_a, w_b[4:0], 1'b0);
      OP_ASH:  w_res = shift_fn(w_a, w_b[4:0], 1'b1);
      OP_LUI:  w_res = {w_b[7:0], 8'h00};
      default: w_we  = 1'b0;
    endcase
  end

  // Commit stage: reset clears everything, otherwise an enabled op writes back.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
      r_flags <= '0;
    end else if (bus.En) begin
      if (w_we) r_regs[bus.RdestRegLoc] <= w_res;
      r_flags <= w_flags_nxt;
    end
  end

  assign bus.RdestOut = r_regs[bus.RdestRegLoc];
  assign bus.Flags    = r_flags;
endmodule

// File: tb/tb_regfile_alu.sv
// Directed testbench for regfile_alu with hand-computed expectations.
module tb_regfile_alu;
  localparam logic [4:0] ADD  = 5'b00000;
  localparam logic [4:0] ADDC = 5'b00010;
  localparam logic [4:0] SUB  = 5'b00011;
  localparam logic [4:0] SUBC = 5'b00100;
  localparam logic [4:0] CMP  = 5'b00101;
  localparam logic [4:0] AND_ = 5'b00110;
  localparam logic [4:0] OR_  = 5'b00111;
  localparam logic [4:0] XOR_ = 5'b01000;
  localparam logic [4:0] NOT_ = 5'b01001;
  localparam logic [4:0] MOV  = 5'b01010;
  localparam logic [4:0] LSH  = 5'b01011;
  localparam logic [4:0] ASH  = 5'b01100;
  localparam logic [4:0] LUI  = 5'b01101;
  localparam logic [4:0] NOP  = 5'b11111;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  regfile_alu_if u_if ();

  regfile_alu dut (
    .Clk (clk),
    .Rst (rst),
    .bus (u_if.slave)
  );

  always #5 clk = ~clk;

  // Apply one enabled operation across a single rising edge.
  task automatic do_op(input logic [4:0] op, input logic [3:0] d, input logic [3:0] s,
                       input logic [15:0] imm, input logic ims);
    u_if.OpCode      = op;
    u_if.RdestRegLoc = d;
    u_if.RsrcRegLoc  = s;
    u_if.Imm         = imm;
    u_if.Imm_s       = ims;
    u_if.En          = 1'b1;
    @(posedge clk);
    #1;
    u_if.En = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    u_if.En = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      u_if.RdestRegLoc = i[3:0];
      #1;
      tests++;
      if (u_if.RdestOut !== 16'h0000) begin
        fails++;
        $display("FAIL reset_R%0d got=%h exp=0000", i, u_if.RdestOut);
      end
    end
    tests++;
    if (u_if.Flags !== 5'b00000) begin
      fails++;
      $display("FAIL reset_flags got=%b exp=00000", u_if.Flags);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_add();
    do_op(MOV, 4'd1, 4'd0, 16'h0005, 1'b1);
    do_op(MOV, 4'd2, 4'd0, 16'h0003, 1'b1);
    do_op(ADD, 4'd1, 4'd2, 16'hFFFF, 1'b0);
    tests++;
    if (u_if.RdestOut !== 16'h0008 || u_if.Flags !== 5'b00000) begin
      fails++;
      $display("FAIL add_reg got=%h/%b exp=0008/00000", u_if.RdestOut, u_if.Flags);
    end
    u_if.OpCode = ADD; u_if.Imm_s = 1'b1; u_if.Imm = 16'h0100;
    u_if.En = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (u_if.RdestOut !== 16'h0008) begin
      fails++;
      $display("FAIL en_low_hold got=%h exp=0008", u_if.RdestOut);
    end
  endtask

  task automatic test_carry();
    do_op(MOV, 4'd1, 4'd0, 16'hFFFF, 1'b1);
    do_op(ADD, 4'd1, 4'd0, 16'h0001, 1'b1);
    tests++;
    if (u_if.RdestOut !== 16'h0000 || u_if.Flags !== 5'b10000) begin
      fails++;
      $display("FAIL add_carry got=%h/%b exp=0000/10000", u_if.RdestOut, u_if.Flags);
    end
    do_op(MOV, 4'd3, 4'd0, 16'h7FFF, 1'b1);
    do_op(ADD, 4'd3, 4'd0, 16'h0001, 1'b1);
    tests++;
    if (u_if.RdestOut !== 16'h8000 || u_if.Flags !== 5'b00100) begin
      fails++;
      $display("FAIL add_ovf got=%h/%b exp=8000/00100", u_if.RdestOut, u_if.Flags);
    end
    do_op(ADDC, 4'd4, 4'd0, 16'h0000, 1'b1);
    tests++;
    if (u_if.RdestOut !== 16'h0000 || u_if.Flags !== 5'b00000) begin
      fails++;
      $display("FAIL addc_c0 got=%h/%b exp=0000/00000", u_if.RdestOut, u_if.Flags);
    end
    do_op(MOV, 4'd1, 4'd0, 16'hFFFF, 1'b1);
    do_op(ADD, 4'd1, 4'd0, 16'h0001, 1'b1);
    do_op(ADDC, 4'd4, 4'd0, 16'h0000, 1'b1);
    tests++;
    if (u_if.RdestOut !== 16'h0001 || u_if.Flags !== 5'b00000) begin
      fails++;
      $display("FAIL addc_c1 got=%h/%b exp=0001/00000", u_if.RdestOut, u_if.Flags);
    end
  endtask

  task automatic test_sub_cmp();
    do_op(MOV, 4'd5, 4'd0, 16'h0003, 1'b1);
    do_op(SUB, 4'd5, 4'd0, 16'h0005, 1'b1);
    tests++;
    if (u_if.RdestOut !== 16'hFFFE || u_if.Flags !== 5'b10000) begin
      fails++;
      $display("FAIL sub_borrow got=%h/%b exp=FFFE/10000", u_if.RdestOut, u_if.Flags);
    end
    do_op(CMP, 4'd5, 4'd0, 16'h0001, 1'b1);
    tests++;
    if (u_if.RdestOut !== 16'hFFFE || u_if.Flags !== 5'b10001) begin
      fails++;
      $display("FAIL cmp_signed got=%h/%b exp=FFFE/10001", u_if.RdestOut, u_if.Flags);
    end
    do_op(MOV, 4'd7, 4'd0, 16'h1234, 1'b1);
    do_op(MOV, 4'd8, 4'd0, 16'h1234, 1'b1);
    do_op(CMP, 4'd7, 4'd8, 16'h0000, 1'b0);
    tests++;
    if (u_if.RdestOut !== 16'h1234 || u_if.Flags !== 5'b10010) begin
      fails++;
      $display("FAIL cmp_equal got=%h/%b exp=1234/10010", u_if.RdestOut, u_if.Flags);
    end
    do_op(CMP, 4'd8, 4'd0, 16'hFFFE, 1'b1);
    tests++;
    if (u_if.Flags !== 5'b11000) begin
      fails++;
      $display("FAIL cmp_unsigned got=%b exp=11000", u_if.Flags);
    end
    do_op(MOV, 4'd10, 4'd0, 16'h0010, 1'b1);
    do_op(SUBC, 4'd10, 4'd0, 16'h0001, 1'b1);
    tests++;
    if (u_if.RdestOut !== 16'h000E || u_if.Flags !== 5'b01000) begin
      fails++;
      $display("FAIL subc got=%h/%b exp=000E/01000", u_if.RdestOut, u_if.Flags);
    end
  endtask

  task automatic test_logic_shift();
    do_op(MOV, 4'd6, 4'd0, 16'h00F0, 1'b1);
    do_op(AND_, 4'd6, 4'd0, 16'h0F3C, 1'b1);
    tests++;
    if (u_if.RdestOut !== 16'h0030) begin
      fails++;
      $display("FAIL and got=%h exp=0030", u_if.RdestOut);
    end
    do_op(MOV, 4'd6, 4'd0, 16'h8001, 1'b1);
    do_op(LSH, 4'd6, 4'd0, 16'h0001, 1'b1);
    tests++;
    if (u_if.RdestOut !== 16'h0002) begin
      fails++;
      $display("FAIL lsh_left got=%h exp=0002", u_if.RdestOut);
    end
    do_op(MOV, 4'd6, 4'd0, 16'h8001, 1'b1);
    do_op(LSH, 4'd6, 4'd0, 16'h0011, 1'b1);
    tests++;
    if (u_if.RdestOut !== 16'h4000) begin
      fails++;
      $display("FAIL lsh_right got=%h exp=4000", u_if.RdestOut);
    end
    do_op(MOV, 4'd6, 4'd0, 16'h8001, 1'b1);
    do_op(ASH, 4'd6, 4'd0, 16'h0011, 1'b1);
    tests++;
    if (u_if.RdestOut !== 16'hC000) begin
      fails++;
      $display("FAIL ash_right got=%h exp=C000", u_if.RdestOut);
    end
    do_op(LUI, 4'd6, 4'd0, 16'h00AB, 1'b1);
    tests++;
    if (u_if.RdestOut !== 16'hAB00) begin
      fails++;
      $display("FAIL lui got=%h exp=AB00", u_if.RdestOut);
    end
    do_op(MOV, 4'd9, 4'd0, 16'h00FF, 1'b1);
    do_op(OR_, 4'd9, 4'd0, 16'h0F00, 1'b1);
    do_op(XOR_, 4'd9, 4'd0, 16'h00F0, 1'b1);
    tests++;
    if (u_if.RdestOut !== 16'h0F0F) begin
      fails++;
      $display("FAIL or_xor got=%h exp=0F0F", u_if.RdestOut);
    end
    do_op(NOT_, 4'd11, 4'd9, 16'h0000, 1'b0);
    tests++;
    if (u_if.RdestOut !== 16'hF0F0) begin
      fails++;
      $display("FAIL not_reg got=%h exp=F0F0", u_if.RdestOut);
    end
  endtask

  task automatic test_misc();
    // Flags currently 01000 from SUBC; NOP must touch nothing.
    do_op(NOP, 4'd9, 4'd0, 16'h1111, 1'b1);
    tests++;
    if (u_if.RdestOut !== 16'h0F0F || u_if.Flags !== 5'b01000) begin
      fails++;
      $display("FAIL nop got=%h/%b exp=0F0F/01000", u_if.RdestOut, u_if.Flags);
    end
    do_op(MOV, 4'd12, 4'd0, 16'h4000, 1'b1);
    do_op(ADD, 4'd12, 4'd12, 16'h0000, 1'b0);
    tests++;
    if (u_if.RdestOut !== 16'h8000 || u_if.Flags !== 5'b01100) begin
      fails++;
      $display("FAIL same_reg got=%h/%b exp=8000/01100", u_if.RdestOut, u_if.Flags);
    end
    do_op(MOV, 4'd0, 4'd0, 16'hBEEF, 1'b1);
    u_if.RdestRegLoc = 4'd6;
    #1;
    tests++;
    if (u_if.RdestOut !== 16'hAB00) begin
      fails++;
      $display("FAIL comb_read_R6 got=%h exp=AB00", u_if.RdestOut);
    end
    u_if.RdestRegLoc = 4'd0;
    #1;
    tests++;
    if (u_if.RdestOut !== 16'hBEEF) begin
      fails++;
      $display("FAIL comb_read_R0 got=%h exp=BEEF", u_if.RdestOut);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rst = 1'b0;
    do_op(ADD, 4'd6, 4'd0, 16'h0001, 1'b1);
    rst = 1'b1;
    tests++;
    if (u_if.RdestOut !== 16'h0000 || u_if.Flags !== 5'b00000) begin
      fails++;
      $display("FAIL reset_mid_R6 got=%h/%b exp=0000/00000", u_if.RdestOut, u_if.Flags);
    end
    u_if.RdestRegLoc = 4'd0;
    #1;
    tests++;
    if (u_if.RdestOut !== 16'h0000) begin
      fails++;
      $display("FAIL reset_mid_R0 got=%h exp=0000", u_if.RdestOut);
    end
    u_if.RdestRegLoc = 4'd9;
    #1;
    tests++;
    if (u_if.RdestOut !== 16'h0000) begin
      fails++;
      $display("FAIL reset_mid_R9 got=%h exp=0000", u_if.RdestOut);
    end
  endtask

  initial begin
    rst              = 1'b0;
    u_if.En          = 1'b0;
    u_if.RdestRegLoc = 4'd0;
    u_if.RsrcRegLoc  = 4'd0;
    u_if.Imm         = 16'h0000;
    u_if.Imm_s       = 1'b0;
    u_if.OpCode      = NOP;
    test_reset();
    test_add();
    test_carry();
    test_sub_cmp();
    test_logic_shift();
    test_misc();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
